// File: rtl/smp_pkg.sv
// SMP run-control shared types: PE request/status bytes,
// host command opcodes, sequencer state encoding.
package smp_pkg;

  typedef struct packed {
    logic step;
    logic halt;
    logic run;
  } req_t;

  typedef struct packed {
    logic alive;
    logic breakpoint;
    logic cpu_halted;
  } stat_t;

  typedef enum logic [1:0] {
    OP_RUN  = 2'd0,
    OP_HALT = 2'd1,
    OP_STEP = 2'd2,
    OP_BOOT = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT,
    S_DONE
  } state_e;

  function automatic req_t op_req(op_e op);
    op_req = '0;
    unique case (op)
      OP_RUN:  op_req.run  = 1'b1;
      OP_BOOT: op_req.run  = 1'b1;
      OP_HALT: op_req.halt = 1'b1;
      OP_STEP: op_req.step = 1'b1;
      default: op_req = '0;
    endcase
  endfunction

endpackage

// File: rtl/smp_sequencer_if.sv
// Host command handshake: valid/ready/op/mask in,
// done pulse, per-CPU error flags and busy out.
interface smp_sequencer_if #(
  parameter int NUM_CPUS = 4
);
  import smp_pkg::*;

  logic                cmd_valid;
  logic                cmd_ready;
  op_e                 cmd_op;
  logic [NUM_CPUS-1:0] cmd_mask;
  logic                done;
  logic [NUM_CPUS-1:0] done_err;
  logic                busy;

  modport master (
    output cmd_valid, cmd_op, cmd_mask,
    input  cmd_ready, done, done_err, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_mask,
    output cmd_ready, done, done_err, busy
  );

endinterface

// File: rtl/smp_seq_track.sv
// Per-CPU completion tracker: sticky ok plus seen_run for STEP.
// Ports: op_i, st_i status, clr_i, en_i (in WAIT and targeted), ok_o.
module smp_seq_track
  import smp_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  op_e   op_i,
  input  stat_t st_i,
  input  logic  clr_i,
  input  logic  en_i,
  output logic  ok_o
);

  logic ok_q;
  logic seen_q;
  logic hit;

  // STEP uses the registered seen_run, so a CPU must be
  // observed running before a halted sample counts.
  always_comb begin
    hit = 1'b0;
    unique case (op_i)
      OP_RUN:  hit = !st_i.cpu_halted;
      OP_HALT: hit = st_i.cpu_halted;
      OP_BOOT: hit = st_i.alive && !st_i.cpu_halted;
      OP_STEP: hit = seen_q && st_i.cpu_halted;
      default: hit = 1'b0;
    endcase
    ok_o = ok_q | (en_i & hit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ok_q   <= 1'b0;
      seen_q <= 1'b0;
    end else if (clr_i) begin
      ok_q   <= 1'b0;
      seen_q <= 1'b0;
    end else if (en_i) begin
      ok_q <= ok_o;
      if (op_i == OP_STEP &&
          (!st_i.cpu_halted || st_i.breakpoint))
        seen_q <= 1'b1;
    end
  end

endmodule

// File: rtl/smp_sequencer.sv
// SMP run-control initiator: fans a command to PE controllers,
// polls status until targets settle or time out. cmd: host if.
module smp_sequencer
  import smp_pkg::*;
#(
  parameter int NUM_CPUS = 4,
  parameter int TIMEOUT  = 1023,
  parameter int SETTLE   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  smp_sequencer_if.slave        cmd,
  output logic [NUM_CPUS-1:0]   pe_write,
  output logic [7:0]            pe_writedata,
  input  logic [8*NUM_CPUS-1:0] pe_readdata
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [SW-1:0] S_LAST = SW'(SETTLE - 1);

  state_e              state_q, state_d;
  op_e                 op_q, op_d;
  logic [NUM_CPUS-1:0] tgt_q, tgt_d;
  logic [NUM_CPUS-1:0] skip_q, skip_d;
  logic [NUM_CPUS-1:0] err_q, err_d;
  logic [TW-1:0]       tcnt_q, tcnt_d;
  logic [SW-1:0]       scnt_q, scnt_d;

  logic [NUM_CPUS-1:0]   alive;
  logic [NUM_CPUS-1:0]   ok;
  logic [NUM_CPUS-1:0]   en;
  logic [5*NUM_CPUS-1:0] hi_bits;
  logic                  unused_hi;
  logic                  clr;
  stat_t                 st [NUM_CPUS];

  assign clr = (state_q == S_ISSUE) || (state_q == S_SETTLE);
  assign en  = (state_q == S_WAIT) ? tgt_q : '0;

  for (genvar g = 0; g < NUM_CPUS; g++) begin : g_cpu
    assign st[g]    = stat_t'(pe_readdata[8*g +: 3]);
    assign alive[g] = st[g].alive;
    assign hi_bits[5*g +: 5] = pe_readdata[8*g+3 +: 5];

    smp_seq_track u_trk (
      .clk   (clk),
      .rst_n (rst_n),
      .op_i  (op_q),
      .st_i  (st[g]),
      .clr_i (clr),
      .en_i  (en[g]),
      .ok_o  (ok[g])
    );
  end

  assign unused_hi = ^hi_bits;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    tgt_d   = tgt_q;
    skip_d  = skip_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;
    scnt_d  = scnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd.cmd_valid) begin
          op_d   = cmd.cmd_op;
          err_d  = '0;
          tcnt_d = '0;
          scnt_d = '0;
          // BOOT targets dead CPUs too: waking them is the point.
          if (cmd.cmd_op == OP_BOOT) begin
            tgt_d  = cmd.cmd_mask;
            skip_d = '0;
          end else begin
            tgt_d  = cmd.cmd_mask & alive;
            skip_d = cmd.cmd_mask & ~alive;
          end
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (tgt_q == '0) begin
          state_d = S_DONE;
          err_d   = err_q | skip_q;
        end else if (SETTLE == 0) begin
          state_d = S_WAIT;
        end else begin
          state_d = S_SETTLE;
        end
      end
      S_SETTLE: begin
        scnt_d = scnt_q + 1'b1;
        if (scnt_q == S_LAST)
          state_d = S_WAIT;
      end
      S_WAIT: begin
        tcnt_d = tcnt_q + 1'b1;
        // skip flags merge on entry to DONE so they are
        // visible in the same cycle as the done pulse.
        if ((ok & tgt_q) == tgt_q) begin
          state_d = S_DONE;
          err_d   = err_q | skip_q;
        end else if (tcnt_q == T_LAST) begin
          state_d = S_DONE;
          err_d   = err_q | skip_q | (tgt_q & ~ok);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      op_q    <= OP_RUN;
      tgt_q   <= '0;
      skip_q  <= '0;
      err_q   <= '0;
      tcnt_q  <= '0;
      scnt_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      tgt_q   <= tgt_d;
      skip_q  <= skip_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
      scnt_q  <= scnt_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign cmd.busy      = (state_q != S_IDLE);
  assign cmd.done      = (state_q == S_DONE);
  assign cmd.done_err  = err_q;

  assign pe_write = (state_q == S_ISSUE) ? tgt_q : '0;
  assign pe_writedata =
    (state_q == S_ISSUE && tgt_q != '0) ?
    {5'b0, op_req(op_q)} : 8'h00;

endmodule

// File: tb/tb_smp_sequencer.sv
// Scoreboard bench for smp_sequencer with behavioural PE models.
// Expected writes/completions queued at issue, checked by monitor.
module tb_smp_sequencer;
  import smp_pkg::*;

  localparam int N  = 4;
  localparam int TO = 30;
  localparam int ST = 2;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   pe_write;
  logic [7:0]     pe_writedata;
  logic [8*N-1:0] pe_readdata;

  smp_sequencer_if #(.NUM_CPUS(N)) cif ();

  smp_sequencer #(
    .NUM_CPUS (N),
    .TIMEOUT  (TO),
    .SETTLE   (ST)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cif),
    .pe_write     (pe_write),
    .pe_writedata (pe_writedata),
    .pe_readdata  (pe_readdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  function automatic void chk(string nm,
                              logic [31:0] a,
                              logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, a, e);
    end
  endfunction

  // PE models
  logic [N-1:0] halted = '0;
  logic [N-1:0] alive  = '1;
  logic [N-1:0] stuck  = '0;
  int pend [N] = '{default: 0};
  int cnt  [N] = '{default: 0};

  always_comb begin
    pe_readdata = '0;
    for (int i = 0; i < N; i++)
      pe_readdata[8*i +: 3] = {alive[i], 1'b0, halted[i]};
  end

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      if (pe_write[i] && !stuck[i]) begin
        if (pe_writedata[1]) begin
          pend[i] <= 1; cnt[i] <= 3;
        end else if (pe_writedata[0]) begin
          pend[i] <= 2; cnt[i] <= 1;
        end else if (pe_writedata[2]) begin
          pend[i] <= 3; cnt[i] <= 1;
        end
      end else if (pend[i] != 0) begin
        if (cnt[i] > 1) cnt[i] <= cnt[i] - 1;
        else begin
          case (pend[i])
            1: begin halted[i] <= 1'b1; pend[i] <= 0; end
            2: begin halted[i] <= 1'b0; pend[i] <= 0; end
            3: begin
              halted[i] <= 1'b0; pend[i] <= 4; cnt[i] <= 4;
            end
            default: begin
              halted[i] <= 1'b1; pend[i] <= 0;
            end
          endcase
        end
      end
    end
  end

  // scoreboard
  typedef struct {
    logic [N-1:0] err;
    int           lat;
    int           t0;
  } exp_t;

  typedef struct {
    logic [N-1:0] wr;
    logic [7:0]   wd;
  } wexp_t;

  exp_t  sbq [$];
  wexp_t wq  [$];
  exp_t  me;
  wexp_t mw;

  always @(negedge clk) begin
    if (cif.done) begin
      chk("done_expected", 32'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        me = sbq.pop_front();
        chk("done_err", 32'(cif.done_err), 32'(me.err));
        if (me.lat != 0)
          chk("done_latency", cyc - me.t0 + 1, me.lat);
      end
    end
    if (pe_write != '0) begin
      chk("write_expected", 32'(wq.size() > 0), 1);
      if (wq.size() > 0) begin
        mw = wq.pop_front();
        chk("pe_write", 32'(pe_write), 32'(mw.wr));
        chk("pe_writedata", 32'(pe_writedata), 32'(mw.wd));
      end
    end
  end

  task automatic issue(input op_e op,
                       input logic [N-1:0] mask,
                       input logic [N-1:0] wr,
                       input logic [7:0] wd,
                       input logic [N-1:0] err,
                       input int lat,
                       input bit push_done);
    int n;
    exp_t e;
    wexp_t w;
    n = 0;
    cif.cmd_op    = op;
    cif.cmd_mask  = mask;
    cif.cmd_valid = 1'b1;
    while (!cif.cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_ready", 32'(cif.cmd_ready), 1);
    @(posedge clk);
    #1;
    cif.cmd_valid = 1'b0;
    if (wr != '0) begin
      w.wr = wr; w.wd = wd;
      wq.push_back(w);
    end
    if (push_done) begin
      e.err = err; e.lat = lat; e.t0 = cyc;
      sbq.push_back(e);
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_timeout", sbq.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    cif.cmd_valid = 1'b0;
    cif.cmd_op    = OP_RUN;
    cif.cmd_mask  = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(cif.cmd_ready), 1);
    chk("rst_busy", 32'(cif.busy), 0);
    chk("rst_done", 32'(cif.done), 0);
    chk("rst_err", 32'(cif.done_err), 0);
    chk("rst_pe_write", 32'(pe_write), 0);
    chk("rst_pe_wd", 32'(pe_writedata), 0);
    @(posedge clk);
    #1;

    // HALT all, models halt 3 cycles after write
    issue(OP_HALT, 4'b1111, 4'b1111, 8'h02, 4'b0000, 6, 1);
    wait_done();
    // HALT again, already halted: minimum latency
    issue(OP_HALT, 4'b1111, 4'b1111, 8'h02, 4'b0000, 5, 1);
    wait_done();
    // STEP CPU1: low 4 cycles then re-halt
    issue(OP_STEP, 4'b0010, 4'b0010, 8'h04, 4'b0000, 8, 1);
    wait_done();
    // STEP CPU1 that never leaves halt
    stuck[1] = 1'b1;
    issue(OP_STEP, 4'b0010, 4'b0010, 8'h04, 4'b0010,
          TO + ST + 2, 1);
    wait_done();
    stuck[1] = 1'b0;
    // BOOT 1-3, CPU3 never alive
    alive[3] = 1'b0;
    stuck[3] = 1'b1;
    issue(OP_BOOT, 4'b1110, 4'b1110, 8'h01, 4'b1000,
          TO + ST + 2, 1);
    wait_done();
    alive[3] = 1'b1;
    stuck[3] = 1'b0;
    // RUN with CPU2 dead: skipped, no timeout
    alive[2] = 1'b0;
    stuck[2] = 1'b1;
    issue(OP_RUN, 4'b0110, 4'b0010, 8'h01, 4'b0100, 5, 1);
    wait_done();
    alive[2] = 1'b1;
    stuck[2] = 1'b0;
    // empty mask
    issue(OP_RUN, 4'b0000, 4'b0000, 8'h00, 4'b0000, 2, 1);
    wait_done();

    // reset during WAIT
    stuck[0] = 1'b1;
    issue(OP_RUN, 4'b0001, 4'b0001, 8'h01, 4'b0000, 0, 0);
    repeat (8) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_pe_write", 32'(pe_write), 0);
    chk("mid_rst_pe_wd", 32'(pe_writedata), 0);
    chk("mid_rst_busy", 32'(cif.busy), 0);
    chk("mid_rst_done", 32'(cif.done), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cif.cmd_ready), 1);
    chk("post_rst_busy", 32'(cif.busy), 0);
    @(posedge clk);
    #1;
    stuck[0] = 1'b0;
    issue(OP_RUN, 4'b0001, 4'b0001, 8'h01, 4'b0000, 5, 1);
    wait_done();

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("wq_empty", wq.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
